pe_array_2d: RTL and testbench

Output-stationary grid of ROWS×COLS signed multiply-accumulate units for the matrix-multiply datapath: ROWS activation lanes are broadcast across COLS weight lanes, so each beat advances ROWS×COLS dot products at once. It replaces the single-weight-column PE array. New over that array: weight-column parallelism, a valid/ready handshake with full-pipeline backpressure, automatic accumulator restart per vector, and per-vector rounding/ReLU requantisation.

---
 rtl/pe_array_2d.sv | 115 +++++++++++
 tb/tb_pe_array_2d.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_2d.sv
// pe_array_2d: output-stationary ROWS x COLS signed multiply-accumulate grid with
// a valid/ready handshake, per-vector accumulator restart and rounding/ReLU requantisation.
module pe_array_2d #(
  parameter int ROWS    = 10,
  parameter int COLS    = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_last,
  input  logic [ROWS-1:0][BW_ACT-1:0]            act_in,
  input  logic [COLS-1:0][BW_WET-1:0]            wet_in,
  input  logic [7:0]                             shift_num,
  input  logic                                   round_en,
  input  logic                                   relu_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ROWS-1:0][COLS-1:0][BW_ACT-1:0]  result_out
);

  localparam int AW = BW_ACCU + 1;
  localparam logic signed [AW-1:0] Q_MAX = AW'((2 ** (BW_ACT - 1)) - 1);
  localparam logic signed [AW-1:0] Q_MIN = -Q_MAX - AW'(1);

  // One spare bit so the rounding bias never overflows for shifts up to BW_ACCU.
  function automatic logic [BW_ACT-1:0] requant(input logic signed [BW_ACCU-1:0] x,
                                                input logic [7:0] s,
                                                input logic rnd,
                                                input logic relu);
    logic signed [AW-1:0] w;
    w = AW'(x);
    if (rnd && (s != 8'd0) && (32'(s) <= 32'(BW_ACCU)))
      w = w + (AW'(1) << (s - 8'd1));
    w = w >>> s;
    if (relu && w[AW-1])
      w = '0;
    if (w > Q_MAX)
      w = Q_MAX;
    else if (w < Q_MIN)
      w = Q_MIN;
    return w[BW_ACT-1:0];
  endfunction

  logic                      en;
  logic                      p_valid;
  logic                      p_last;
  logic                      first;
  logic [7:0]                p_shift;
  logic                      p_round;
  logic                      p_relu;
  logic signed [BW_ACCU-1:0] prod [ROWS][COLS];
  logic signed [BW_ACCU-1:0] acc  [ROWS][COLS];
  logic signed [BW_ACCU-1:0] sum  [ROWS][COLS];
  logic [BW_ACT-1:0]         q    [ROWS][COLS];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        sum[r][c] = (first ? '0 : acc[r][c]) + prod[r][c];
        q[r][c]   = requant(sum[r][c], p_shift, p_round, p_relu);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid    <= 1'b0;
      p_last     <= 1'b0;
      first      <= 1'b1;
      p_shift    <= '0;
      p_round    <= 1'b0;
      p_relu     <= 1'b0;
      out_valid  <= 1'b0;
      result_out <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          prod[r][c] <= '0;
          acc[r][c]  <= '0;
        end
      end
    end else if (en) begin
      p_valid <= in_valid;
      p_last  <= in_last;
      p_shift <= shift_num;
      p_round <= round_en;
      p_relu  <= relu_en;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          prod[r][c] <= BW_ACCU'($signed(act_in[r])) * BW_ACCU'($signed(wet_in[c]));
        end
      end
      if (p_valid) begin
        first <= p_last;
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            if (!p_last)
              acc[r][c] <= sum[r][c];
            else
              result_out[r][c] <= q[r][c];
          end
        end
      end
      // A consumed tile is replaced in the same cycle when a vector completes.
      out_valid <= p_valid && p_last;
    end
  end

endmodule

// File: tb/tb_pe_array_2d.sv
// tb_pe_array_2d: random and directed stimulus for pe_array_2d, checked against a
// dot-product / requantisation reference model with a tile scoreboard.
module tb_pe_array_2d;

  localparam int ROWS    = 10;
  localparam int COLS    = 4;
  localparam int BW_ACT  = 8;
  localparam int BW_WET  = 8;
  localparam int BW_ACCU = 32;
  localparam int TW      = ROWS * COLS * BW_ACT;
  localparam int MAXLEN  = 150;

  typedef logic [ROWS-1:0][COLS-1:0][BW_ACT-1:0] tile_t;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [ROWS-1:0][BW_ACT-1:0]    act_in;
  logic [COLS-1:0][BW_WET-1:0]    wet_in;
  logic [7:0]                     shift_num;
  logic                           round_en;
  logic                           relu_en;
  logic                           out_valid;
  logic                           out_ready;
  tile_t                          result_out;

  pe_array_2d #(
    .ROWS(ROWS), .COLS(COLS), .BW_ACT(BW_ACT), .BW_WET(BW_WET), .BW_ACCU(BW_ACCU)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .act_in(act_in), .wet_in(wet_in), .shift_num(shift_num),
    .round_en(round_en), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  tile_t exp_q[$];
  logic [1:0] hist = 2'b00;
  bit    chk_lat   = 1'b0;
  bit    rand_ready = 1'b0;
  int    stall_left = 0;
  bit    stalling   = 1'b0;
  tile_t snap;

  int va [MAXLEN][ROWS];
  int vw [MAXLEN][COLS];
  int ga [100][150];
  int gb [150][16];

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW_ACT-1:0] qmodel(input longint x, input int s, input bit rnd,
                                               input bit relu);
    longint v;
    longint lim;
    lim = longint'(1) <<< (BW_ACT - 1);
    v = longint'(int'(x));
    if (rnd && s > 0) v += longint'(1) << (s - 1);
    if (s >= 63) v = (v < 0) ? -1 : 0;
    else v = v >>> s;
    if (relu && v < 0) v = 0;
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
    return v[BW_ACT-1:0];
  endfunction

  // One clock: sample at the negedge, then return at posedge+1 for the next drive.
  task automatic step(output bit acc);
    if (stall_left > 0 && out_valid) begin
      out_ready = 1'b0;
      if (!stalling) begin
        snap = result_out;
        stalling = 1'b1;
      end
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalling = 1'b0;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    if (stalling) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_result_hold", result_out, snap);
      stall_left--;
    end
    if (out_valid && out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("tile", result_out, exp_q.pop_front());
    end
    if (chk_lat) check("latency_out_valid", out_valid, hist[1]);
    hist = {hist[0], acc && in_last};
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int len, input int s, input bit rnd, input bit relu,
                          input int max_bubble, input bit use_const,
                          input logic [BW_ACT-1:0] cval);
    tile_t t;
    bit    a;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        longint acc_sum = 0;
        for (int k = 0; k < len; k++) acc_sum += longint'(va[k][r]) * longint'(vw[k][c]);
        t[r][c] = use_const ? cval : qmodel(acc_sum, s, rnd, relu);
      end
    end
    for (int k = 0; k < len; k++) begin
      int nb = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
      for (int b = 0; b < nb; b++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        act_in   = {ROWS{8'($urandom)}};
        step(a);
      end
      in_valid = 1'b1;
      in_last  = (k == len - 1);
      for (int r = 0; r < ROWS; r++) act_in[r] = va[k][r][BW_ACT-1:0];
      for (int c = 0; c < COLS; c++) wet_in[c] = vw[k][c][BW_WET-1:0];
      if (k == len - 1) begin
        shift_num = 8'(s);
        round_en  = rnd;
        relu_en   = relu;
      end else begin
        shift_num = 8'($urandom);
        round_en  = 1'($urandom_range(0, 1));
        relu_en   = 1'($urandom_range(0, 1));
      end
      a = 1'b0;
      for (int tries = 0; tries < 100 && !a; tries++) step(a);
      if (!a) check("accept_timeout", a, 1'b1);
      if (a && k == len - 1) exp_q.push_back(t);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill_const(input int len, input int av, input int wv);
    for (int k = 0; k < len; k++) begin
      for (int r = 0; r < ROWS; r++) va[k][r] = av;
      for (int c = 0; c < COLS; c++) vw[k][c] = wv;
    end
  endtask

  task automatic fill_rand(input int len);
    for (int k = 0; k < len; k++) begin
      for (int r = 0; r < ROWS; r++) va[k][r] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) vw[k][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step(a);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    bit a;
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; act_in = '0; wet_in = '0;
    shift_num = '0; round_en = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result_out, '0);
    reset = 1'b0;

    // Rounding, saturation, ReLU and wide-shift corners.
    chk_lat = 1'b1;
    fill_const(1, 3, 1);   send_vec(1, 1, 1'b1, 1'b0, 0, 1'b1, 8'sd2);
    fill_const(1, 3, 1);   send_vec(1, 1, 1'b0, 1'b0, 0, 1'b1, 8'sd1);
    fill_const(1, -3, 1);  send_vec(1, 1, 1'b1, 1'b0, 0, 1'b1, -8'sd1);
    fill_const(1, -3, 1);  send_vec(1, 1, 1'b0, 1'b0, 0, 1'b1, -8'sd2);
    fill_const(4, 127, 127); send_vec(4, 0, 1'b0, 1'b0, 0, 1'b1, 8'sd127);
    fill_const(1, -128, 127); send_vec(1, 0, 1'b0, 1'b0, 0, 1'b1, -8'sd128);
    fill_const(1, -128, 127); send_vec(1, 0, 1'b0, 1'b1, 0, 1'b1, 8'sd0);
    fill_const(1, -5, 1);  send_vec(1, 40, 1'b0, 1'b0, 0, 1'b1, -8'sd1);

    // Back-to-back single-beat tiles: out_valid must stay high as tiles replace each other.
    for (int i = 0; i < 4; i++) begin
      fill_rand(1);
      send_vec(1, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, '0);
    end
    drain();

    // Backpressure: tile held for 7 cycles while the next vector pushes in.
    chk_lat = 1'b0;
    stall_left = 7;
    fill_rand(2); send_vec(2, 6, 1'b0, 1'b0, 0, 1'b0, '0);
    fill_rand(3); send_vec(3, 7, 1'b1, 1'b0, 0, 1'b0, '0);
    drain();
    check("bp_stall_done", stall_left, 0);

    // Reset in the middle of a vector drops the partial sum.
    fill_rand(2);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_last = 1'b0;
      for (int r = 0; r < ROWS; r++) act_in[r] = va[k][r][BW_ACT-1:0];
      for (int c = 0; c < COLS; c++) wet_in[c] = vw[k][c][BW_WET-1:0];
      step(a);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_result", result_out, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    hist = 2'b00;
    fill_rand(3); send_vec(3, 5, 1'b0, 1'b0, 0, 1'b0, '0);
    drain();

    // Golden GEMM: 100x150 by 150x16, tiled 10x4, one 150-beat vector per tile.
    for (int i = 0; i < 100; i++)
      for (int k = 0; k < 150; k++) ga[i][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 150; k++)
      for (int j = 0; j < 16; j++) gb[k][j] = int'($urandom_range(0, 255)) - 128;
    chk_lat = 1'b1;
    for (int rb = 0; rb < 100 / ROWS; rb++) begin
      for (int cb = 0; cb < 16 / COLS; cb++) begin
        for (int k = 0; k < 150; k++) begin
          for (int r = 0; r < ROWS; r++) va[k][r] = ga[rb * ROWS + r][k];
          for (int c = 0; c < COLS; c++) vw[k][c] = gb[k][cb * COLS + c];
        end
        send_vec(150, 8, 1'b0, 1'b0, (rb % 2), 1'b0, '0);
      end
    end
    drain();

    // Random short vectors, random config and random consumer readiness.
    chk_lat = 1'b0;
    rand_ready = 1'b1;
    for (int v = 0; v < 30; v++) begin
      int len = int'($urandom_range(1, 6));
      fill_rand(len);
      send_vec(len, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2, 1'b0, '0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
